// File: rtl/ifetch_queue.sv
// Instruction fetch unit: issues sequential word fetches into a 1-cycle
// synchronous memory and queues {pc, data} for decode; redirect restarts.
module ifetch_queue #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              imem_addr,
  output logic                     imem_rd,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_addr,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst_data,
  output logic [31:0]              inst_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_W = OW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   pc_mem_d [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   data_mem_d [DEPTH];

  logic          pop;
  logic          push;
  logic          issue;
  logic [OW-1:0] occ;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^redirect_addr[1:0];

  assign inst_valid = (count_q != '0) & ~redirect_valid;
  assign pop        = inst_valid & inst_ready;
  assign push       = inflight_q & ~redirect_valid;

  // Slots committed after this edge; issuing only below DEPTH prevents overflow.
  assign occ   = {1'b0, count_q}
               + {{CW{1'b0}}, inflight_q}
               - {{CW{1'b0}}, pop};
  assign issue = ~reset & ~redirect_valid & (occ < DEPTH_W);

  assign imem_addr = fetch_pc_q;
  assign imem_rd   = issue;
  assign inst_data = data_mem_q[rd_ptr_q];
  assign inst_pc   = pc_mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    pc_mem_d      = pc_mem_q;
    data_mem_d    = data_mem_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_addr[31:2], 2'b00};
      inflight_d = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end else if (push) begin
        inflight_d = 1'b0;
      end
      if (push) begin
        pc_mem_d[wr_ptr_q]   = inflight_pc_q;
        data_mem_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_ADDR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      pc_mem_q      <= pc_mem_d;
      data_mem_q    <= data_mem_d;
    end
  end

endmodule
